clint: RTL
==========

# clint

Core-local interruptor: memory-mapped machine timer and software-interrupt source that drives the `mtip` and `msip` inputs of the CSR block. Sits on the data-memory bus beside DMEM and UART. Owns a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip` register. Raises `mtip` when `mtime >= mtimecmp`.

## Interface
- `BASE_ADDR`, default 32'h0200_0000: region base; only `addr[31:16]` is compared.
- `TICK_DIV`, default 1: clock cycles per `mtime` increment; 0 is treated as 1; range 0..65535.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  bus request strobe.
- `req_ready`  out  1  request accepted this cycle.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address, word aligned.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte enables for writes.
- `rsp_valid`  out  1  response strobe, one cycle wide.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  unmapped or misaligned access, valid with `rsp_valid`.
- `mtip`  out  1  machine timer interrupt pending, to CSR.
- `msip`  out  1  machine software interrupt pending, to CSR.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - 0x0000: `msip`. Only bit 0 is stored; other bits read 0.
  - 0x4000 / 0x4004: `mtimecmp` low / high.
  - 0xBFF8 / 0xBFFC: `mtime` low / high.
- Errors: any other offset, `addr[1:0] != 0`, or `addr[31:16] != BASE_ADDR[31:16]` gives `rsp_err = 1` and `rsp_rdata = 0`. No register changes.
- Writes: merged per byte using `req_wstrb`. `wstrb = 0` is legal and has no effect.
- Prescaler: a 16-bit counter counts 0..`TICK_DIV`-1.
  - On wrap, `mtime` increments by 1.
  - `mtime` wraps from 2^64-1 to 0 with no flag.
- Write/increment collision: a write to either `mtime` half in the same cycle as an increment wins.
  - The written half takes the written value.
  - The other half keeps its current value, with no carry applied.
  - The prescaler is not reset.
- Half writes: writing the `mtime` low half never carries into the high half.
- `mtip`: registered `(mtime >= mtimecmp)`, unsigned 64-bit compare, evaluated on post-update values. It clears only by raising `mtimecmp` or lowering `mtime`; there is no sticky state.
- Handshake:
  - One outstanding request at a time.
  - `req_ready = !rsp_pending`.
  - A request is accepted when `req_valid && req_ready`.
  - `req_*` are sampled only on acceptance.
  - `req_valid` held high after acceptance is treated as a new request once `req_ready` returns.

## Timing
- Reset values:
  - `mtime = 0`, `mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF`, prescaler = 0.
  - `msip`, `mtip`, `rsp_valid`, `rsp_err`, `rsp_rdata` = 0.
  - `req_ready = 1`.
- Access latency:
  - Accept in cycle N; the register write takes effect at the end of N.
  - `rsp_valid`, `rsp_rdata`, `rsp_err` are valid in cycle N+1, with `req_ready = 0` during N+1.
  - Next accept is possible in N+2, i.e. at most one access every 2 cycles.
- Read snapshot: read data is the register value at the end of cycle N, i.e. it includes any increment in N.
- `mtip` latency: one cycle after the compare condition changes. A write to `mtimecmp` in cycle N is reflected on `mtip` in cycle N+1.
- `msip` follows the stored bit with the same one-cycle latency as the write.
- Reset mid-transaction:
  - Any pending response is dropped; `rsp_valid = 0` in the cycle after `rst`.
  - All registers return to their reset values.
- `mtime` runs continuously, independent of bus activity and of pipeline stalls.

## Configuration
- `CLINT_MTIME_WR_EN` defined: `mtime` low/high are writable as described above.
- Not defined:
  - `mtime` is read-only.
  - Writes to 0xBFF8/0xBFFC complete with `rsp_err = 1` and leave `mtime` unchanged.
  - The collision rule does not apply.

## Test plan
- Reset, then read 0x4000/0x4004 -> `FFFFFFFF`/`FFFFFFFF`; `mtip = 0`; `msip = 0`.
- `TICK_DIV = 4`: read `mtime` low at cycle 0 and cycle 40 after reset -> values differ by exactly 10.
- Write `mtimecmp` high = 0, then low = 0x20, with `TICK_DIV = 1` -> `mtip` rises exactly one cycle after `mtime` reaches 0x20. Write `mtimecmp` low = 0xFFFF_FFFF -> `mtip` falls the next cycle.
- `msip` and strobes:
  - Write 0xFFFF_FFFF to 0x0000 -> `msip = 1` next cycle; read returns 0x1.
  - Write with `wstrb = 4'b0000` -> no change.
- With `CLINT_MTIME_WR_EN`, collision: write `mtime` low = 0xFFFF_FFFF, high = 0, then wait one tick -> high = 1, low = 0. A write issued on a tick cycle stores the written value, not value+1.
- Error paths and reset:
  - Access to 0x1000, a misaligned address, or a foreign base -> `rsp_err = 1`, `rsp_rdata = 0`, state unchanged.
  - Assert `rst` during a pending response -> no `rsp_valid`.

Source files
------------

// File: rtl/clint.sv
// clint - core-local interruptor.
// Memory-mapped machine timer (64-bit mtime / mtimecmp) and software
// interrupt bit. It drives the mtip and msip inputs of the CSR block.
//
// Parameters:
//   BASE_ADDR  region base; only bits [31:16] take part in the decode
//   TICK_DIV   clock cycles per mtime increment (0 behaves as 1)
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   req_valid/req_ready       request handshake, one outstanding access
//   req_we, req_addr,
//   req_wdata, req_wstrb      request fields, sampled on acceptance
//   rsp_valid, rsp_rdata,
//   rsp_err                   one-cycle response, the cycle after acceptance
//   mtip                      registered (mtime >= mtimecmp)
//   msip                      stored software interrupt bit
//
// Build option:
//   CLINT_MTIME_WR_EN         when defined, mtime low/high are writable;
//                             otherwise writes to them return rsp_err.

module clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mtip,
  output logic        msip
);

  localparam logic [15:0] PRESC_LAST = (TICK_DIV == 0) ? 16'd0 : 16'(TICK_DIV - 32'd1);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI
  } sel_e;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] presc_q, presc_d;
  logic        msip_q, msip_d;
  logic        mtip_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q, rdata_d;
  logic        rsp_err_q, err_d;
  logic        accept, tick;
  sel_e        sel;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  always_comb begin
    sel = SEL_NONE;
    if (req_addr[31:16] == BASE_ADDR[31:16] && req_addr[1:0] == 2'b00) begin
      case (req_addr[15:0])
        16'h0000: sel = SEL_MSIP;
        16'h4000: sel = SEL_CMP_LO;
        16'h4004: sel = SEL_CMP_HI;
        16'hBFF8: sel = SEL_TIME_LO;
        16'hBFFC: sel = SEL_TIME_HI;
        default:  sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    accept     = req_valid && !rsp_valid_q;
    tick       = (presc_q == PRESC_LAST);
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = 32'd0;
    err_d      = 1'b0;

    if (accept) begin
      if (sel == SEL_NONE) begin
        err_d = 1'b1;
      end else if (req_we) begin
        case (sel)
          SEL_MSIP:   msip_d = req_wstrb[0] ? req_wdata[0] : msip_q;
          SEL_CMP_LO: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], req_wdata, req_wstrb);
          SEL_CMP_HI: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], req_wdata, req_wstrb);
`ifdef CLINT_MTIME_WR_EN
          // A half write overrides a same-cycle increment: the other half
          // keeps its current value and no carry crosses between halves.
          SEL_TIME_LO: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], req_wdata, req_wstrb)};
          SEL_TIME_HI: mtime_d = {merge(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]};
`else
          SEL_TIME_LO, SEL_TIME_HI: err_d = 1'b1;
`endif
          default: ;
        endcase
      end else begin
        // Reads return the value as it stands at the end of this cycle.
        case (sel)
          SEL_MSIP:    rdata_d = {31'd0, msip_d};
          SEL_CMP_LO:  rdata_d = mtimecmp_d[31:0];
          SEL_CMP_HI:  rdata_d = mtimecmp_d[63:32];
          SEL_TIME_LO: rdata_d = mtime_d[31:0];
          SEL_TIME_HI: rdata_d = mtime_d[63:32];
          default:     rdata_d = 32'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= '1;
      presc_q     <= 16'd0;
      msip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      presc_q     <= presc_d;
      msip_q      <= msip_d;
      mtip_q      <= (mtime_d >= mtimecmp_d);
      rsp_valid_q <= accept;
      rsp_rdata_q <= rdata_d;
      rsp_err_q   <= err_d;
    end
  end

  assign req_ready = !rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mtip      = mtip_q;
  assign msip      = msip_q;

endmodule
